result_wb_packer: RTL and testbench



---
 rtl/result_wb_packer.sv | 94 +++++++++
 tb/tb_result_wb_packer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/result_wb_packer.sv
// result_wb_packer: masks adder result words, buffers them in a small FIFO and
// writes one frame of sequentially addressed words to the HASH BRAM port.
module result_wb_packer #(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 4,
  parameter int LOGQ        = 15,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 2688,
  parameter int ADDR_STEP   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [31:0]                 base_addr,
  input  logic                        mask_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  input  logic                        hash_ready,
  output logic [31:0]                 addr_HASH,
  output logic                        wen_HASH,
  output logic [DATA_WIDTH*LANES-1:0] bram_wdata_HASH,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 word_cnt,
  output logic                        overflow_err
);
  localparam int W = DATA_WIDTH * LANES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] LANE_MASK = DATA_WIDTH'((64'd1 << LOGQ) - 64'd1);
  localparam logic [W-1:0] WORD_MASK = {LANES{LANE_MASK}};
  localparam logic [15:0] FRAME_N = 16'(FRAME_WORDS);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [31:0] wr_addr;
  logic [15:0] acc_cnt;
  logic mask_q, full, empty, push, pop, go;
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign go = (state == IDLE) && start;
  assign in_ready = (state == RUN) && !full && (acc_cnt < FRAME_N);
  assign push = in_valid && in_ready;
  assign pop = (state == RUN) && !empty && hash_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_d = go ? RUN :
              (pop && word_cnt == FRAME_N - 16'd1) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= mask_q ? (in_data & WORD_MASK) : in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      wr_addr <= '0;
      mask_q <= 1'b0;
      acc_cnt <= '0;
      word_cnt <= '0;
      overflow_err <= 1'b0;
      addr_HASH <= '0;
      wen_HASH <= 1'b0;
      bram_wdata_HASH <= '0;
    end else begin
      wen_HASH <= pop;
      if (go) begin
        wr_addr <= base_addr;
        mask_q <= mask_en;
        acc_cnt <= '0;
        word_cnt <= '0;
        overflow_err <= 1'b0;
        wp <= '0;
        rp <= '0;
      end
      if (push) begin
        wp <= wp + PTR_ONE;
        acc_cnt <= acc_cnt + 16'd1;
      end
      if (pop) begin
        rp <= rp + PTR_ONE;
        addr_HASH <= wr_addr;
        bram_wdata_HASH <= mem[rp[AW-1:0]];
        wr_addr <= wr_addr + 32'(ADDR_STEP);
        word_cnt <= word_cnt + 16'd1;
      end
      if (state == RUN && in_valid && acc_cnt == FRAME_N) overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_result_wb_packer.sv
// tb_result_wb_packer: directed frames with hand-computed addresses/data for result_wb_packer.
module tb_result_wb_packer;
  logic clk = 1'b0;
  logic rst, start, mask_en, in_valid, hash_ready, in_ready, wen_HASH, busy, done, overflow_err;
  logic [31:0] base_addr, addr_HASH;
  logic [63:0] in_data, bram_wdata_HASH;
  logic [15:0] word_cnt;
  int n_vec = 0, n_err = 0, done_cnt = 0, d0 = 0, w0 = 0, acc_total = 0, wr_total = 0, max_occ = 0;
  logic [31:0] wa [$];
  logic [63:0] wd [$];
  logic [63:0] expq [$];
  localparam logic [63:0] QMASK = 64'h7FFF_7FFF_7FFF_7FFF;
  always #5 clk = ~clk;
  result_wb_packer #(.FRAME_WORDS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .mask_en(mask_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .hash_ready(hash_ready),
    .addr_HASH(addr_HASH), .wen_HASH(wen_HASH), .bram_wdata_HASH(bram_wdata_HASH),
    .busy(busy), .done(done), .word_cnt(word_cnt), .overflow_err(overflow_err)
  );
  always @(negedge clk) begin
    if (wen_HASH) begin
      wa.push_back(addr_HASH);
      wd.push_back(bram_wdata_HASH);
      wr_total++;
    end
    if (done) done_cnt++;
    if (acc_total - wr_total > max_occ) max_occ = acc_total - wr_total;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_start(input logic [31:0] b, input logic m);
    start = 1'b1;
    base_addr = b;
    mask_en = m;
    d0 = done_cnt;
    w0 = wa.size();
    expq.delete();
    tick();
    start = 1'b0;
  endtask
  task automatic stream(input int n, input logic [63:0] seed, input bit msk, input bit toggle);
    int k = 0;
    int g = 0;
    logic acc;
    while (k < n && g < 300) begin
      in_valid = 1'b1;
      in_data = seed + 64'(k);
      if (toggle) hash_ready = (g % 2) == 0;
      acc = in_ready;
      tick();
      if (acc) begin
        expq.push_back(msk ? (in_data & QMASK) : in_data);
        k++;
        acc_total++;
      end
      g++;
    end
    in_valid = 1'b0;
    chk("accepts", 64'(k), 64'(n));
  endtask
  task automatic wait_done();
    int i = 0;
    while (done_cnt == d0 && i < 100) begin
      tick();
      i++;
    end
    repeat (3) tick();
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
  endtask
  task automatic check_frame(input logic [31:0] b);
    chk("n_writes", 64'(wa.size() - w0), 64'(expq.size()));
    for (int i = 0; i < expq.size() && w0 + i < wa.size(); i++) begin
      chk($sformatf("addr%0d", i), 64'(wa[w0+i]), 64'(b) + 64'(i));
      chk($sformatf("data%0d", i), wd[w0+i], expq[i]);
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; mask_en = 1'b0; in_valid = 1'b0; hash_ready = 1'b1;
    base_addr = '0; in_data = '0;
    tick(); tick();
    chk("rst_addr", 64'(addr_HASH), 64'd0);
    chk("rst_data", bram_wdata_HASH, 64'd0);
    chk("rst_ctl", 64'({in_ready, wen_HASH, busy, done, overflow_err}), 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    rst = 1'b0;
    tick();
    // basic frame
    do_start(32'h100, 1'b0);
    chk("busy_run", 64'(busy), 64'd1);
    stream(8, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
    wait_done();
    check_frame(32'h100);
    chk("word_cnt", 64'(word_cnt), 64'd8);
    // masking
    do_start(32'h0, 1'b1);
    stream(8, 64'hFFFF_8001_7FFF_8000, 1'b1, 1'b0);
    wait_done();
    check_frame(32'h0);
    if (wd.size() > w0) chk("mask_word0", wd[w0], 64'h7FFF_0001_7FFF_0000);
    else chk("mask_word0_present", 64'(wd.size()), 64'(w0 + 1));
    // backpressure: FIFO fills after 4 words, nothing lost
    hash_ready = 1'b0;
    do_start(32'h300, 1'b0);
    stream(4, 64'h3000, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = 64'h3004;
    for (int i = 0; i < 6; i++) begin
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_no_writes", 64'(wa.size() - w0), 64'd0);
    hash_ready = 1'b1;
    stream(4, 64'h3004, 1'b0, 1'b0);
    wait_done();
    check_frame(32'h300);
    // toggling hash_ready
    do_start(32'h400, 1'b0);
    stream(8, 64'h4000, 1'b0, 1'b1);
    hash_ready = 1'b1;
    wait_done();
    check_frame(32'h400);
    chk("max_occ_le4", 64'(max_occ <= 4), 64'd1);
    // overflow and ignored start
    do_start(32'h500, 1'b0);
    stream(8, 64'h5000, 1'b0, 1'b0);
    in_valid = 1'b1;
    hash_ready = 1'b0;
    tick();
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_ready", 64'(in_ready), 64'd0);
    start = 1'b1;
    base_addr = 32'h999;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("ign_start_addr", 64'(addr_HASH), 64'h506);
    chk("ign_start_rdy", 64'(in_ready), 64'd0);
    chk("ovf_hold", 64'(overflow_err), 64'd1);
    hash_ready = 1'b1;
    wait_done();
    check_frame(32'h500);
    chk("ovf_idle", 64'(overflow_err), 64'd1);
    // reset mid-frame
    do_start(32'h600, 1'b0);
    chk("ovf_clear", 64'(overflow_err), 64'd0);
    stream(3, 64'hA000, 1'b0, 1'b0);
    for (int i = 0; i < 20 && wa.size() - w0 < 3; i++) tick();
    chk("pre_rst_writes", 64'(wa.size() - w0), 64'd3);
    hash_ready = 1'b0;
    stream(1, 64'hDEAD, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_addr", 64'(addr_HASH), 64'd0);
    chk("mid_rst_data", bram_wdata_HASH, 64'd0);
    chk("mid_rst_ctl", 64'({in_ready, wen_HASH, busy, done, overflow_err}), 64'd0);
    chk("mid_rst_cnt", 64'(word_cnt), 64'd0);
    rst = 1'b0;
    hash_ready = 1'b1;
    d0 = done_cnt;
    tick();
    chk("no_done_on_rst", 64'(done_cnt - d0), 64'd0);
    do_start(32'h200, 1'b0);
    stream(8, 64'h1111_0000, 1'b0, 1'b0);
    wait_done();
    check_frame(32'h200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
